// File: rtl/pipe_trace_buffer.sv
// Trace FIFO for MIPS WB register writes and MEM stores, with cycle stamps
// and saturating stall/flush/drop statistics.
module pipe_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CYC_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     wb_regwrite_i,
  input  logic [4:0]               wb_regaddr_i,
  input  logic [31:0]              wb_result_i,
  input  logic                     mem_memwrite_i,
  input  logic [31:0]              mem_aluout_i,
  input  logic [31:0]              mem_writedata_i,
  input  logic                     stall_pc_i,
  input  logic                     flush_exe_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic                     trace_kind_o,
  output logic [CYC_W-1:0]         trace_cycle_o,
  output logic [31:0]              trace_addr_o,
  output logic [31:0]              trace_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic             kind;
    logic [CYC_W-1:0] cycle;
    logic [31:0]      addr;
    logic [31:0]      data;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    st_slot;
  logic [CYC_W-1:0] cyc;

  logic       reg_ev, st_ev, full, one_free;
  logic       push_reg, push_st, drop_reg, drop_st, pop;
  logic [1:0] n_push, n_drop;
  rec_t       reg_rec, st_rec, head;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    sat_add = s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Admission: room is judged on start-of-cycle occupancy; register record has priority
  always_comb begin
    reg_ev   = en_i & wb_regwrite_i & (wb_regaddr_i != 5'd0);
    st_ev    = en_i & mem_memwrite_i;
    full     = (level_o == LW'(DEPTH));
    one_free = (level_o == LW'(DEPTH - 1));
    push_reg = reg_ev & ~full;
    push_st  = st_ev & ~full & ~(one_free & reg_ev);
    drop_reg = reg_ev & ~push_reg;
    drop_st  = st_ev & ~push_st;
    n_push   = {1'b0, push_reg} + {1'b0, push_st};
    n_drop   = {1'b0, drop_reg} + {1'b0, drop_st};
    pop      = trace_valid_o & trace_ready_i;
    st_slot  = wr_ptr + AW'(push_reg);
    reg_rec  = '{kind: 1'b0, cycle: cyc, addr: {27'd0, wb_regaddr_i}, data: wb_result_i};
    st_rec   = '{kind: 1'b1, cycle: cyc, addr: mem_aluout_i, data: mem_writedata_i};
  end

  always_ff @(posedge clk) begin
    if (push_reg) mem[wr_ptr]  <= reg_rec;
    if (push_st)  mem[st_slot] <= st_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      cyc         <= '0;
      overflow_o  <= 1'b0;
      drop_cnt_o  <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(n_push);
      rd_ptr  <= rd_ptr + AW'(pop);
      level_o <= level_o + LW'(n_push) - LW'(pop);
      if (en_i) cyc <= cyc + CYC_W'(1);
      if (clr_i) begin
        overflow_o  <= 1'b0;
        drop_cnt_o  <= '0;
        stall_cnt_o <= '0;
        flush_cnt_o <= '0;
      end else begin
        overflow_o  <= overflow_o | (n_drop != 2'd0);
        drop_cnt_o  <= sat_add(drop_cnt_o, n_drop);
        stall_cnt_o <= sat_add(stall_cnt_o, {1'b0, en_i & stall_pc_i});
        flush_cnt_o <= sat_add(flush_cnt_o, {1'b0, en_i & flush_exe_i});
      end
    end
  end

  // Show-ahead head; fields forced to zero while the FIFO is empty
  always_comb begin
    head          = mem[rd_ptr];
    trace_valid_o = (level_o != '0);
    trace_kind_o  = trace_valid_o ? head.kind  : 1'b0;
    trace_cycle_o = trace_valid_o ? head.cycle : '0;
    trace_addr_o  = trace_valid_o ? head.addr  : '0;
    trace_data_o  = trace_valid_o ? head.data  : '0;
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: directed vector table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_pipe_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CYC_W = 8;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, en, clr, rw, mw, stall, flush, ready;
  logic [4:0]  ra;
  logic [31:0] rr, ma, md;
  logic             t_valid, t_kind, ovf;
  logic [CYC_W-1:0] t_cyc;
  logic [31:0]      t_addr, t_data;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drop_cnt, stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en_i(en), .clr_i(clr),
    .wb_regwrite_i(rw), .wb_regaddr_i(ra), .wb_result_i(rr),
    .mem_memwrite_i(mw), .mem_aluout_i(ma), .mem_writedata_i(md),
    .stall_pc_i(stall), .flush_exe_i(flush),
    .trace_valid_o(t_valid), .trace_ready_i(ready), .trace_kind_o(t_kind),
    .trace_cycle_o(t_cyc), .trace_addr_o(t_addr), .trace_data_o(t_data),
    .level_o(level), .overflow_o(ovf), .drop_cnt_o(drop_cnt),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: record queue plus plain integer counters
  typedef struct {
    logic             kind;
    logic [CYC_W-1:0] cyc;
    logic [31:0]      addr;
    logic [31:0]      data;
  } mrec_t;

  mrec_t m_q[$];
  int    m_cyc, m_drop, m_stall, m_flush;
  bit    m_ovf;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_update();
    mrec_t ev[$];
    mrec_t acc[$];
    mrec_t r;
    int free, drops;
    bit pop;
    if (rst) begin
      m_q.delete();
      m_cyc = 0; m_drop = 0; m_stall = 0; m_flush = 0; m_ovf = 0;
      return;
    end
    if (en && rw && ra != 5'd0) begin
      r.kind = 1'b0; r.cyc = CYC_W'(m_cyc); r.addr = {27'd0, ra}; r.data = rr;
      ev.push_back(r);
    end
    if (en && mw) begin
      r.kind = 1'b1; r.cyc = CYC_W'(m_cyc); r.addr = ma; r.data = md;
      ev.push_back(r);
    end
    free  = DEPTH - m_q.size();
    drops = 0;
    foreach (ev[k]) begin
      if (free > 0) begin acc.push_back(ev[k]); free--; end
      else drops++;
    end
    pop = (m_q.size() != 0) && ready;
    if (pop) void'(m_q.pop_front());
    foreach (acc[k]) m_q.push_back(acc[k]);
    if (clr) begin
      m_drop = 0; m_stall = 0; m_flush = 0; m_ovf = 0;
    end else begin
      m_drop  = sat(m_drop + drops);
      m_ovf   = m_ovf | (drops > 0);
      m_stall = sat(m_stall + ((en && stall) ? 1 : 0));
      m_flush = sat(m_flush + ((en && flush) ? 1 : 0));
    end
    if (en) m_cyc = (m_cyc + 1) % (1 << CYC_W);
  endtask

  task automatic check_model();
    cmp("m_valid", 64'(t_valid), 64'(m_q.size() != 0));
    cmp("m_level", 64'(level), 64'(m_q.size()));
    cmp("m_ovf", 64'(ovf), 64'(m_ovf));
    cmp("m_drop", 64'(drop_cnt), 64'(m_drop));
    cmp("m_stall", 64'(stall_cnt), 64'(m_stall));
    cmp("m_flush", 64'(flush_cnt), 64'(m_flush));
    if (m_q.size() != 0) begin
      cmp("m_kind", 64'(t_kind), 64'(m_q[0].kind));
      cmp("m_cycle", 64'(t_cyc), 64'(m_q[0].cyc));
      cmp("m_addr", 64'(t_addr), 64'(m_q[0].addr));
      cmp("m_data", 64'(t_data), 64'(m_q[0].data));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    en = 1'b1; clr = 1'b0; rw = 1'b0; ra = '0; rr = '0;
    mw = 1'b0; ma = '0; md = '0; stall = 1'b0; flush = 1'b0; ready = 1'b0;
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected after it
  typedef struct {
    logic             en, rw;
    logic [4:0]       ra;
    logic [31:0]      rr;
    logic             mw;
    logic [31:0]      ma, md;
    logic             ready;
    logic             ev, ek;
    logic [CYC_W-1:0] ec;
    logic [31:0]      ea, ed;
    int               el;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic w, input logic [4:0] a,
                              input logic [31:0] r, input logic m, input logic [31:0] sa,
                              input logic [31:0] sd, input logic rd, input logic xv,
                              input logic xk, input int xc, input logic [31:0] xa,
                              input logic [31:0] xd, input int xl);
    vec_t v;
    v.en = e; v.rw = w; v.ra = a; v.rr = r; v.mw = m; v.ma = sa; v.md = sd;
    v.ready = rd; v.ev = xv; v.ek = xk; v.ec = CYC_W'(xc); v.ea = xa; v.ed = xd; v.el = xl;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    logic [CYC_W-1:0] s0;
    logic [31:0]      held;

    tbl[0] = mk(1, 0, 0, 0,     0, 0,     0,     0, 0, 0, 0, 0,     0,     0);
    tbl[1] = mk(1, 0, 0, 0,     0, 0,     0,     0, 0, 0, 0, 0,     0,     0);
    tbl[2] = mk(1, 0, 0, 0,     0, 0,     0,     0, 0, 0, 0, 0,     0,     0);
    tbl[3] = mk(1, 1, 8, 32'h5, 0, 0,     0,     0, 1, 0, 3, 32'h8, 32'h5, 1);
    tbl[4] = mk(1, 0, 0, 0,     0, 0,     0,     1, 0, 0, 0, 0,     0,     0);
    tbl[5] = mk(1, 1, 9, 32'hAA, 1, 32'h10, 32'h55, 0, 1, 0, 5, 32'h9, 32'hAA, 2);
    tbl[6] = mk(1, 0, 0, 0,     0, 0,     0,     1, 1, 1, 5, 32'h10, 32'h55, 1);
    tbl[7] = mk(1, 0, 0, 0,     0, 0,     0,     1, 0, 0, 0, 0,     0,     0);
    tbl[8] = mk(1, 1, 0, 32'h77, 0, 0,    0,     0, 0, 0, 0, 0,     0,     0);
    tbl[9] = mk(0, 1, 3, 32'h1, 1, 32'h20, 32'h2, 0, 0, 0, 0, 0,     0,     0);

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    cmp("rst_valid", 64'(t_valid), 64'd0);
    cmp("rst_level", 64'(level), 64'd0);
    cmp("rst_fields", {t_kind, 31'(t_cyc), t_addr | t_data}, 64'd0);
    cmp("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      en = tbl[i].en; rw = tbl[i].rw; ra = tbl[i].ra; rr = tbl[i].rr;
      mw = tbl[i].mw; ma = tbl[i].ma; md = tbl[i].md; ready = tbl[i].ready;
      step();
      cmp($sformatf("vec%0d_valid", i), 64'(t_valid), 64'(tbl[i].ev));
      cmp($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].el));
      if (tbl[i].ev) begin
        cmp($sformatf("vec%0d_kind", i), 64'(t_kind), 64'(tbl[i].ek));
        cmp($sformatf("vec%0d_cycle", i), 64'(t_cyc), 64'(tbl[i].ec));
        cmp($sformatf("vec%0d_addr", i), 64'(t_addr), 64'(tbl[i].ea));
        cmp($sformatf("vec%0d_data", i), 64'(t_data), 64'(tbl[i].ed));
      end
    end

    // Overflow: 17 writes into a 16-deep FIFO under backpressure, then drain
    idle_inputs();
    s0 = CYC_W'(m_cyc);
    for (int i = 0; i < 17; i++) begin
      rw = 1'b1; ra = 5'((i % 31) + 1); rr = 32'h1000 + 32'(i);
      step();
    end
    rw = 1'b0;
    cmp("ovf_level", 64'(level), 64'd16);
    cmp("ovf_flag", 64'(ovf), 64'd1);
    cmp("ovf_drop", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 16; i++) begin
      cmp("drain_data", 64'(t_data), 64'(32'h1000 + 32'(i)));
      cmp("drain_cycle", 64'(t_cyc), 64'(s0 + CYC_W'(i)));
      held = t_data;
      ready = 1'b0;
      step();
      cmp("hold_data", 64'(t_data), 64'(held));
      ready = 1'b1;
      step();
    end
    ready = 1'b0;
    cmp("drain_empty", 64'(t_valid), 64'd0);

    // One free slot with a dual event and a simultaneous pop
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rw = 1'b1; ra = 5'd4; rr = 32'h2000 + 32'(i);
      step();
    end
    cmp("l15_level", 64'(level), 64'd15);
    rw = 1'b1; ra = 5'd7; rr = 32'hDEAD; mw = 1'b1; ma = 32'h40; md = 32'hBEEF; ready = 1'b1;
    step();
    rw = 1'b0; mw = 1'b0;
    cmp("dual_level", 64'(level), 64'd15);
    cmp("dual_drop", 64'(drop_cnt), 64'd1);
    cmp("dual_ovf", 64'(ovf), 64'd1);
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        cmp("dual_last_kind", 64'(t_kind), 64'd0);
        cmp("dual_last_data", 64'(t_data), 64'hDEAD);
      end
      step();
    end
    cmp("dual_empty", 64'(level), 64'd0);

    // Stall/flush counting, enable gating, clear priority, mid-drain reset
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
    stall = 1'b1;
    repeat (4) step();
    stall = 1'b0; flush = 1'b1;
    repeat (2) step();
    flush = 1'b0; en = 1'b0; stall = 1'b1;
    repeat (3) step();
    cmp("stall_cnt", 64'(stall_cnt), 64'd4);
    cmp("flush_cnt", 64'(flush_cnt), 64'd2);
    en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0; stall = 1'b0;
    cmp("clr_stall", 64'(stall_cnt), 64'd0);
    cmp("clr_flush", 64'(flush_cnt), 64'd0);
    rw = 1'b1; ra = 5'd2; rr = 32'h3;
    repeat (3) step();
    rw = 1'b0; ready = 1'b1;
    step();
    rst = 1'b1; rw = 1'b1; mw = 1'b1;
    step();
    rst = 1'b0; rw = 1'b0; mw = 1'b0; ready = 1'b0;
    cmp("midrst_valid", 64'(t_valid), 64'd0);
    cmp("midrst_level", 64'(level), 64'd0);
    cmp("midrst_fields", {t_kind, 31'(t_cyc), t_addr | t_data}, 64'd0);

    // Randomized traffic with phases of light and heavy backpressure
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 999) == 0);
      en    = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 63) == 0);
      rw    = $urandom_range(0, 1) == 1;
      ra    = 5'($urandom_range(0, 31));
      rr    = $urandom;
      mw    = ($urandom_range(0, 2) == 0);
      ma    = $urandom;
      md    = $urandom;
      stall = $urandom_range(0, 1) == 1;
      flush = $urandom_range(0, 1) == 1;
      ready = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
